prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 38 +++
 rtl/ldr_timeout.sv | 29 ++
 rtl/prog_loader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Holds the FSM state encoding, error codes and default frame magic byte.
package prog_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MAGIC,
    ST_COUNT,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_MAGIC   = 3'd1,
    ERR_FORMAT  = 3'd2,
    ERR_CSUM    = 3'd3,
    ERR_TIMEOUT = 3'd4
  } err_code_t;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

  // States in which the loader is willing to take a byte from the stream.
  function automatic logic is_rx_state(input state_t s);
    return (s == ST_MAGIC) || (s == ST_COUNT) || (s == ST_HI) ||
           (s == ST_LO) || (s == ST_CSUM);
  endfunction

  function automatic logic is_busy_state(input state_t s);
    return (s == ST_MAGIC) || (s == ST_COUNT) || (s == ST_HI) ||
           (s == ST_LO) || (s == ST_WRITE) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/ldr_timeout.sv
// Inter-byte idle watchdog: counts enabled cycles since the last clear and
// flags expiry once the count sits at TIMEOUT_CYC-1.
module ldr_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so expiry stays asserted until the FSM reacts.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/prog_loader.sv
// Receives a MAGIC/COUNT/HI-LO pairs/CSUM frame from a byte stream and
// writes the 12-bit words into program memory while holding the CPU.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0] MAGIC       = DEFAULT_MAGIC,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        load_en,
  output logic [7:0]  load_addr,
  output logic [11:0] load_I,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code
);

  state_t    state, state_nxt;
  err_code_t err_q, err_nxt;

  logic [7:0] addr;
  logic [7:0] acc;
  logic [7:0] count_n;
  logic [3:0] hi_nib;

  logic accept, restart, expired, tmo_enable, tmo_clear;

  assign accept     = rx_valid && rx_ready;
  assign restart    = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign tmo_enable = (state == ST_COUNT) || (state == ST_HI) || (state == ST_LO) || (state == ST_CSUM);
  assign tmo_clear  = accept || restart;

  ldr_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (expired)
  );

  // Next-state and error selection; an accepted byte always wins over expiry.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_nxt = ST_MAGIC;
          err_nxt   = ERR_NONE;
        end
      end
      ST_MAGIC: begin
        if (accept) begin
          if (rx_data == MAGIC) begin
            state_nxt = ST_COUNT;
          end else begin
            state_nxt = ST_ERROR;
            err_nxt   = ERR_MAGIC;
          end
        end
      end
      ST_COUNT: begin
        if (accept) begin
          state_nxt = ST_HI;
        end else if (expired) begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_HI: begin
        if (accept) begin
          if (rx_data[7:4] != 4'h0) begin
            state_nxt = ST_ERROR;
            err_nxt   = ERR_FORMAT;
          end else begin
            state_nxt = ST_LO;
          end
        end else if (expired) begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_LO: begin
        if (accept) begin
          state_nxt = ST_WRITE;
        end else if (expired) begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      // A count of 0 means 256: addr+1 wraps to 0 after the last word.
      ST_WRITE: begin
        state_nxt = ((addr + 8'd1) == count_n) ? ST_CSUM : ST_HI;
      end
      ST_CSUM: begin
        if (accept) begin
          if (rx_data == acc) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_ERROR;
            err_nxt   = ERR_CSUM;
          end
        end else if (expired) begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      err_q     <= ERR_NONE;
      addr      <= '0;
      acc       <= '0;
      count_n   <= '0;
      hi_nib    <= '0;
      rx_ready  <= 1'b0;
      load_en   <= 1'b0;
      load_addr <= '0;
      load_I    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      state    <= state_nxt;
      err_q    <= err_nxt;
      rx_ready <= is_rx_state(state_nxt);
      busy     <= is_busy_state(state_nxt);
      done     <= (state_nxt == ST_DONE);
      err      <= (state_nxt == ST_ERROR);
      cpu_hold <= (state_nxt != ST_DONE);

      if (state_nxt == ST_WRITE) begin
        load_en   <= 1'b1;
        load_addr <= addr;
        load_I    <= {hi_nib, rx_data};
      end else begin
        load_en   <= 1'b0;
        load_addr <= '0;
        load_I    <= '0;
      end

      if (restart) begin
        addr <= '0;
        acc  <= '0;
      end else if (state == ST_WRITE) begin
        addr <= addr + 8'd1;
      end

      if (accept) begin
        case (state)
          ST_COUNT: begin
            count_n <= rx_data;
            acc     <= rx_data;
          end
          ST_HI: begin
            hi_nib <= rx_data[3:0];
            acc    <= acc + rx_data;
          end
          ST_LO: begin
            acc <= acc + rx_data;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign err_code = err_q;

endmodule
